// File: rtl/adpll_lock_monitor.sv
// adpll_lock_monitor
//   Lock-quality monitor for the ADPLL test tops, clocked by the fabric clock.
//   The reference clock is synchronised and edge-detected. Each rising edge
//   captures the signed phase error. The captured sample drives the following:
//     - a lock/slip FSM with hysteresis,
//     - an |error| and peak-|error| capture,
//     - a saturating slip counter,
//     - a reference-loss timeout.
//
//   Optional feature: define ADPLL_LOCK_ERROR_AVG_EN to add a signed block
//   average of 2^AVG_LOG2 samples on err_avg_o/avg_valid_o. When the macro is
//   undefined, both outputs are tied to 0.
//
// Ports
//   fpga_clk_i     fabric clock (sole clock)
//   rst_n_i        asynchronous active-low reset
//   enable_i       monitor enable
//   ref_clk_i      reference clock, asynchronous to fpga_clk_i
//   error_i        signed phase error, stable around reference edges
//   clear_i        single-cycle clear of peak and slip count
//   state_o        00 UNLOCKED, 01 ACQUIRING, 10 LOCKED, 11 SLIPPING
//   locked_o       state is LOCKED or SLIPPING
//   ref_lost_o     reference timeout flag
//   sample_valid_o one-cycle pulse; error_abs_o carries the new sample
//   error_abs_o    unsigned |sample|
//   error_peak_o   max error_abs_o since reset/clear
//   slip_count_o   saturating count of LOCKED->SLIPPING transitions
//   err_avg_o      signed block average (optional)
//   avg_valid_o    pulse with err_avg_o (optional)
module adpll_lock_monitor #(
  parameter int ERR_WIDTH     = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int LOCK_THRESH   = 4,
  parameter int LOCK_COUNT    = 16,
  parameter int UNLOCK_COUNT  = 4,
  parameter int TIMEOUT_WIDTH = 16,
  parameter int AVG_LOG2      = 3
) (
  input  logic                        fpga_clk_i,
  input  logic                        rst_n_i,
  input  logic                        enable_i,
  input  logic                        ref_clk_i,
  input  logic signed [ERR_WIDTH-1:0] error_i,
  input  logic                        clear_i,
  output logic [1:0]                  state_o,
  output logic                        locked_o,
  output logic                        ref_lost_o,
  output logic                        sample_valid_o,
  output logic [ERR_WIDTH-1:0]        error_abs_o,
  output logic [ERR_WIDTH-1:0]        error_peak_o,
  output logic [15:0]                 slip_count_o,
  output logic signed [ERR_WIDTH-1:0] err_avg_o,
  output logic                        avg_valid_o
);

  localparam int CNT_MAX = (LOCK_COUNT > UNLOCK_COUNT) ? LOCK_COUNT : UNLOCK_COUNT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0]         LOCK_LAST   = CNT_W'(LOCK_COUNT - 1);
  localparam logic [CNT_W-1:0]         UNLOCK_LAST = CNT_W'(UNLOCK_COUNT - 1);
  localparam logic [ERR_WIDTH:0]       THRESH      = (ERR_WIDTH + 1)'(LOCK_THRESH);
  localparam logic [TIMEOUT_WIDTH-1:0] TMO_MAX     = {TIMEOUT_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    UNLOCKED  = 2'b00,
    ACQUIRING = 2'b01,
    LOCKED    = 2'b10,
    SLIPPING  = 2'b11
  } state_t;

  // |e| evaluated one bit wider so that -2^(W-1) maps to 2^(W-1) exactly.
  function automatic logic [ERR_WIDTH-1:0] abs_err(input logic signed [ERR_WIDTH-1:0] e);
    logic signed [ERR_WIDTH:0] ext;
    ext = {e[ERR_WIDTH-1], e};
    if (ext < 0) ext = -ext;
    return ext[ERR_WIDTH-1:0];
  endfunction

  // Reference synchroniser and edge detect
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   ref_edge;

  always_ff @(posedge fpga_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ref_clk_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign ref_edge = sync_q[SYNC_STAGES-1] & ~prev_q;

  // Sample capture on the edge cycle; processing happens while vld_q is high
  logic signed [ERR_WIDTH-1:0] sample_q;
  logic                        vld_q;

  always_ff @(posedge fpga_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sample_q <= '0;
      vld_q    <= 1'b0;
    end else begin
      vld_q <= enable_i & ref_edge;
      if (enable_i && ref_edge) sample_q <= error_i;
    end
  end

  logic [ERR_WIDTH-1:0] err_abs;
  logic                 in_window;
  logic                 proc;

  assign err_abs   = abs_err(sample_q);
  assign in_window = ({1'b0, err_abs} <= THRESH);
  assign proc      = vld_q & enable_i;

  // Lock FSM, hysteresis counter and reference timeout
  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [TIMEOUT_WIDTH-1:0] tmo_q, tmo_d;
  logic                     lost_q, lost_d;
  logic                     tmo_hit;
  logic                     slip_evt;

  always_ff @(posedge fpga_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= UNLOCKED;
      cnt_q   <= '0;
      tmo_q   <= '0;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      lost_q  <= lost_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
    lost_d   = lost_q;
    tmo_hit  = 1'b0;
    slip_evt = 1'b0;
    if (!enable_i) begin
      state_d = UNLOCKED;
      cnt_d   = '0;
      tmo_d   = '0;
      lost_d  = 1'b0;
    end else begin
      if (proc) begin
        unique case (state_q)
          UNLOCKED: begin
            if (in_window) begin
              state_d = ACQUIRING;
              cnt_d   = CNT_W'(1);
            end
          end
          ACQUIRING: begin
            if (!in_window) begin
              state_d = UNLOCKED;
              cnt_d   = '0;
            end else if (cnt_q == LOCK_LAST) begin
              state_d = LOCKED;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          LOCKED: begin
            if (!in_window) begin
              state_d  = SLIPPING;
              cnt_d    = CNT_W'(1);
              slip_evt = 1'b1;
            end
          end
          SLIPPING: begin
            if (in_window) begin
              state_d = LOCKED;
              cnt_d   = '0;
            end else if (cnt_q == UNLOCK_LAST) begin
              state_d = UNLOCKED;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          default: begin
            state_d = UNLOCKED;
            cnt_d   = '0;
          end
        endcase
      end
      // An edge restarts the timeout; the counter parks at its maximum.
      if (ref_edge) begin
        tmo_d  = '0;
        lost_d = 1'b0;
      end else if (tmo_q != TMO_MAX) begin
        tmo_d = tmo_q + 1'b1;
        if (tmo_d == TMO_MAX) begin
          tmo_hit = 1'b1;
          lost_d  = 1'b1;
          state_d = UNLOCKED;
          cnt_d   = '0;
        end
      end
    end
  end

  // Peak and slip statistics; a coincident sample/slip wins over clear
  logic [ERR_WIDTH-1:0] peak_q, peak_d;
  logic [15:0]          slip_q, slip_d;

  always_ff @(posedge fpga_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      peak_q <= '0;
      slip_q <= '0;
    end else begin
      peak_q <= peak_d;
      slip_q <= slip_d;
    end
  end

  always_comb begin
    peak_d = peak_q;
    slip_d = slip_q;
    if (clear_i) begin
      peak_d = '0;
      slip_d = '0;
    end
    if (proc && (clear_i || (err_abs > peak_q))) peak_d = err_abs;
    if (slip_evt) begin
      if (clear_i)                slip_d = 16'd1;
      else if (slip_q != 16'hFFFF) slip_d = slip_q + 16'd1;
    end
  end

  assign state_o        = state_q;
  assign locked_o       = state_q[1];
  assign ref_lost_o     = lost_q;
  assign sample_valid_o = vld_q;
  assign error_abs_o    = err_abs;
  assign error_peak_o   = peak_q;
  assign slip_count_o   = slip_q;

`ifdef ADPLL_LOCK_ERROR_AVG_EN
  // Block averager
  localparam int ACC_W = ERR_WIDTH + AVG_LOG2;

  logic signed [ACC_W-1:0]     acc_q, acc_sum, acc_shift;
  logic [AVG_LOG2-1:0]         blk_q;
  logic signed [ERR_WIDTH-1:0] avg_q, avg_new;
  logic                        blk_last;

  assign acc_sum   = acc_q + $signed({{AVG_LOG2{sample_q[ERR_WIDTH-1]}}, sample_q});
  assign acc_shift = acc_sum >>> AVG_LOG2;
  assign avg_new   = acc_shift[ERR_WIDTH-1:0];
  assign blk_last  = (blk_q == {AVG_LOG2{1'b1}});

  always_ff @(posedge fpga_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      acc_q <= '0;
      blk_q <= '0;
      avg_q <= '0;
    end else if (!enable_i || tmo_hit) begin
      acc_q <= '0;
      blk_q <= '0;
    end else if (proc) begin
      if (blk_last) begin
        acc_q <= '0;
        blk_q <= '0;
        avg_q <= avg_new;
      end else begin
        acc_q <= acc_sum;
        blk_q <= blk_q + 1'b1;
      end
    end
  end

  assign avg_valid_o = proc & blk_last;
  assign err_avg_o   = avg_valid_o ? avg_new : avg_q;
`else
  logic unused_avg_cfg;
  assign unused_avg_cfg = ^AVG_LOG2;
  assign err_avg_o      = '0;
  assign avg_valid_o    = 1'b0;
`endif

endmodule

// File: doc/adpll_lock_monitor.md
Name: adpll_lock_monitor

Overview:
- Lock-quality monitor for the ADPLL test tops. Runs on the fast fabric clock.
- Samples the ADPLL signed phase error on each rising edge of a reference clock. The reference is generated or external and is synchronised internally.
- Lock/slip FSM with hysteresis, reference-loss timeout, |error| and peak-|error| capture, and a slip counter, all for display or debug.
- Parametrised in error width, windows, counts and timeout.

Parameters:
ERR_WIDTH, 8, width of signed error_i
SYNC_STAGES, 2, ref_clk_i synchroniser depth (>=2)
LOCK_THRESH, 4, in-window when |error| <= LOCK_THRESH
LOCK_COUNT, 16, consecutive in-window samples to lock (>=2)
UNLOCK_COUNT, 4, consecutive out-of-window samples to unlock (>=2)
TIMEOUT_WIDTH, 16, ref loss after 2^TIMEOUT_WIDTH-1 clocks with no edge
AVG_LOG2, 3, log2 samples per average block (optional feature)

Ports:
fpga_clk_i  in  1  fabric clock, sole clock
rst_n_i  in  1  asynchronous active-low reset
enable_i  in  1  monitor enable
ref_clk_i  in  1  reference clock, asynchronous to fpga_clk_i
error_i  in  ERR_WIDTH  signed phase error, stable around ref edges
clear_i  in  1  single-cycle clear of peak and slip count
state_o  out  2  00 UNLOCKED, 01 ACQUIRING, 10 LOCKED, 11 SLIPPING
locked_o  out  1  state_o is LOCKED or SLIPPING
ref_lost_o  out  1  reference timeout flag
sample_valid_o  out  1  one-cycle pulse, error_abs_o updated
error_abs_o  out  ERR_WIDTH  unsigned |sample|; -2^(W-1) gives 2^(W-1) exactly
error_peak_o  out  ERR_WIDTH  max error_abs since reset/clear
slip_count_o  out  16  saturating count of LOCKED->SLIPPING transitions
err_avg_o  out  ERR_WIDTH  signed block average (optional feature)
avg_valid_o  out  1  pulse with err_avg_o (optional feature)

Behaviour:
- Reset: all outputs, state, counters and synchroniser flops are 0.
- Edge detect: ref_clk_i passes through SYNC_STAGES flops, then one more flop; edge = sync & ~prev.
- Edge cycle: error_i captured. Next cycle: sample_valid_o=1, error_abs_o updated, error_peak_o updated, FSM advances.
- Latency from ref rise to sample_valid_o: SYNC_STAGES+1 to SYNC_STAGES+2 clocks.
- In-window test: |sample| <= LOCK_THRESH, computed at width ERR_WIDTH+1 so nothing overflows.
- UNLOCKED:
  - In-window: go to ACQUIRING, cnt=1.
  - Otherwise: stay.
- ACQUIRING:
  - In-window: cnt++. Go to LOCKED when cnt would reach LOCK_COUNT; cnt=0.
  - Out-of-window: go to UNLOCKED, cnt=0.
- LOCKED:
  - Out-of-window: go to SLIPPING, cnt=1, slip_count_o++ (saturates at 65535).
- SLIPPING:
  - Out-of-window: cnt++. Go to UNLOCKED when cnt would reach UNLOCK_COUNT.
  - In-window: go to LOCKED, cnt=0.
- Timeout counter:
  - Cleared on every edge.
  - On reaching 2^TIMEOUT_WIDTH-1: ref_lost_o=1, state=UNLOCKED, cnt=0, then holds.
  - ref_lost_o clears on the next edge; that edge's sample is processed normally.
- enable_i=0:
  - State forced UNLOCKED, cnt=0, timeout counter 0, ref_lost_o=0.
  - Edges ignored: no sample_valid_o.
  - error_peak_o and slip_count_o hold.
- clear_i:
  - Clears error_peak_o and slip_count_o.
  - Coincident with sample_valid_o: peak = new error_abs_o.
  - Coincident with a slip: slip_count_o=1.
- Async reset mid-operation: immediate return to reset values; first edge after release is processed normally.

Optional Feature:
- Macro ADPLL_LOCK_ERROR_AVG_EN.
- Defined:
  - Accumulator of ERR_WIDTH+AVG_LOG2 bits sums 2^AVG_LOG2 consecutive samples.
  - After the last sample of a block: err_avg_o = sum >>> AVG_LOG2 (arithmetic, floor), and avg_valid_o pulses on the same cycle as that sample's sample_valid_o.
  - Accumulator restarts on the next sample.
  - enable_i=0 or ref loss discards the partial block.
- Undefined: err_avg_o and avg_valid_o tied to 0; no accumulator logic.

Test Plan:
1. Hold rst_n_i low with toggling inputs -> all outputs 0 and state_o=00; release -> first ref edge gives sample_valid_o after 3-4 clocks.
2. Ref period 258 clocks, error_i=3 for 16 edges -> state 01 after edge 1, 10 after edge 16, locked_o=1. Repeat with error_i=5 at edge 10 -> state 00.
3. From LOCKED, error_i=-9 for 3 edges -> state 11, locked_o=1, slip_count_o=1. Then error_i=0 -> state 10. Then -9 for 4 edges -> state 00, locked_o=0.
4. Samples -128 then 7 -> error_abs_o 128 then 7, error_peak_o=128. clear_i coincident with sample 7 -> error_peak_o=7.
5. While locked, stop ref for 65535 clocks -> ref_lost_o=1, state 00. Restart ref -> ref_lost_o=0 on first sample_valid_o. Separately, enable_i=0 mid-acquire -> state 00, peak held.
6. With ADPLL_LOCK_ERROR_AVG_EN: 8 samples of -3 -> err_avg_o=-3. Sum +1 -> 0. Sum -1 -> -1. avg_valid_o once per 8 samples. Without the macro, both outputs stay 0.
